// File: rtl/tx_shift_pkg.sv
// Shared definitions for the transmit ping-pong shifter.
//   - Parameter legality limits checked at elaboration time.
//   - State encoding for the shifter control FSM (IDLE / SHIFT).
package tx_shift_pkg;

  localparam int MIN_WIDTH = 8;
  localparam int MAX_WIDTH = 64;
  localparam int MIN_NBUF  = 2;
  localparam int MAX_NBUF  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/tx_word_fifo.sv
// NBUF-deep word store for the transmit shifter.
// Words are written at wptr and read (unmodified) at rptr; both pointers wrap
// modulo NBUF. level/empty/full are registered and reflect the post-edge count.
// Ports:
//   clk, rst        clock, async active-high reset
//   push, wdata     write one word (caller guarantees !full)
//   pop             release the head word (caller guarantees !empty)
//   head            word at rptr, combinational read
//   empty, full     registered status flags
//   level           number of stored words
module tx_word_fifo
  import tx_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NBUF  = 2,
  localparam int PW   = $clog2(NBUF),
  localparam int LW   = $clog2(NBUF + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  localparam logic [PW-1:0] LAST_PTR = PW'(NBUF - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(NBUF);

  logic [WIDTH-1:0] mem [NBUF];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [LW-1:0]    level_nxt;

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;  // none, or simultaneous push+pop
    endcase
  end

  // Storage carries no reset: contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (push) wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == FULL_LVL);
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/tx_pingpong_shifter.sv
// Serial transmitter fed from a small ring of word buffers.
// Words are enqueued in parallel and emitted one bit per accepted shift,
// LSB-first or MSB-first. The head word is never shifted in place; a bit
// counter selects the outgoing bit instead.
//
// Handshake: a load transfers exactly on a rising edge where
// load_valid & load_ready; load_ready = cs & !full is combinational and uses
// the registered full flag, so a slot freed by a final-bit shift in the same
// cycle is not visible to the load until the next cycle. A shift is accepted
// on cs & shift_en & !empty; a request that is not accepted is dropped.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   cs                  chip select; low freezes all state
//   load_valid/data     word offer; load_ready accept indication
//   shift_en            request one output bit
//   dout, dout_valid    registered serial bit and its strobe
//   word_done           pulse with the last bit of each word
//   empty, full, level  buffer occupancy
//   state               control FSM state (IDLE=0, SHIFT=1), for observation
module tx_pingpong_shifter
  import tx_shift_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NBUF      = 2,
  parameter bit MSB_FIRST = 1'b0,
  localparam int LW       = $clog2(NBUF + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level,
  output logic [0:0]       state
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);
  localparam logic [0:0]    ST_IDLE  = IDLE;
  localparam logic [0:0]    ST_SHIFT = SHIFT;

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("tx_pingpong_shifter: WIDTH=%0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
  end
  if (NBUF < MIN_NBUF || NBUF > MAX_NBUF) begin : g_bad_nbuf
    $error("tx_pingpong_shifter: NBUF=%0d outside %0d..%0d", NBUF, MIN_NBUF, MAX_NBUF);
  end

  logic [WIDTH-1:0] head;
  logic [BW-1:0]    bidx;
  logic [BW-1:0]    sel;
  logic [0:0]       state_q;
  logic [0:0]       state_nxt;
  logic             load_acc;
  logic             shift_acc;
  logic             last_bit;

  assign load_ready = cs & ~full;
  assign load_acc   = load_valid & load_ready;
  assign shift_acc  = cs & shift_en & ~empty;
  assign last_bit   = shift_acc & (bidx == LAST_IDX);
  assign sel        = MSB_FIRST ? (LAST_IDX - bidx) : bidx;

  tx_word_fifo #(
    .WIDTH (WIDTH),
    .NBUF  (NBUF)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (load_acc),
    .wdata (load_data),
    .pop   (last_bit),
    .head  (head),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  // Return to IDLE only when the final bit of the only stored word leaves
  // and no replacement word arrives on the same edge.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (load_acc) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit && level == LW'(1) && !load_acc) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bidx       <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      dout_valid <= shift_acc;
      word_done  <= last_bit;
      if (shift_acc) begin
        dout <= head[sel];
        bidx <= last_bit ? '0 : bidx + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_tx_pingpong_shifter.sv
// Directed bench for tx_pingpong_shifter: two WIDTH=8, NBUF=2 instances share
// every input; instance a shifts LSB-first, instance b MSB-first.
module tb_tx_pingpong_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       shift_en = 1'b0;

  logic       load_ready_a, dout_a, dout_valid_a, word_done_a, empty_a, full_a;
  logic [1:0] level_a;
  logic [0:0] state_a;
  logic       load_ready_b, dout_b, dout_valid_b, word_done_b, empty_b, full_b;
  logic [1:0] level_b;
  logic [0:0] state_b;

  int checks = 0;
  int errors = 0;

  tx_pingpong_shifter #(.WIDTH(8), .NBUF(2), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .cs(cs), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready_a), .shift_en(shift_en), .dout(dout_a),
    .dout_valid(dout_valid_a), .word_done(word_done_a), .empty(empty_a),
    .full(full_a), .level(level_a), .state(state_a)
  );

  tx_pingpong_shifter #(.WIDTH(8), .NBUF(2), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .cs(cs), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready_b), .shift_en(shift_en), .dout(dout_b),
    .dout_valid(dout_valid_b), .word_done(word_done_b), .empty(empty_b),
    .full(full_b), .level(level_b), .state(state_b)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks (no checking)
  task automatic do_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] w);
    load_valid = 1'b1;
    load_data  = w;
    shift_en   = 1'b0;
    do_cycle();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) do_cycle();
    checks++; if (dout_a !== 1'b0 || dout_b !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b/%b want 0", dout_a, dout_b); end
    checks++; if (dout_valid_a !== 1'b0 || word_done_a !== 1'b0) begin errors++; $display("FAIL reset_strobes: got dv=%b wd=%b want 0", dout_valid_a, word_done_a); end
    checks++; if (empty_a !== 1'b1 || full_a !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", empty_a, full_a); end
    checks++; if (level_a !== 2'd0 || state_a !== 1'b0) begin errors++; $display("FAIL reset_level_state: got level=%0d state=%0d want 0/0", level_a, state_a); end
    rst = 1'b0;
    cs  = 1'b1;
  endtask

  task automatic test_bit_order();
    logic [7:0] words [2];
    logic [7:0] seq_a [2];
    logic [7:0] seq_b [2];
    words[0] = 8'hA5; seq_a[0] = 8'hA5; seq_b[0] = 8'hA5;
    words[1] = 8'h1E; seq_a[1] = 8'h1E; seq_b[1] = 8'h78;
    for (int w = 0; w < 2; w++) begin
      load_word(words[w]);
      checks++; if (level_a !== 2'd1 || empty_a !== 1'b0 || state_a !== 1'b1) begin errors++; $display("FAIL order_load w%0d: got level=%0d empty=%b state=%0d want 1/0/1", w, level_a, empty_a, state_a); end
      shift_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
        do_cycle();
        checks++; if (dout_a !== seq_a[w][i]) begin errors++; $display("FAIL order_lsb w%0d bit%0d: got %b want %b", w, i, dout_a, seq_a[w][i]); end
        checks++; if (dout_b !== seq_b[w][i]) begin errors++; $display("FAIL order_msb w%0d bit%0d: got %b want %b", w, i, dout_b, seq_b[w][i]); end
        checks++; if (dout_valid_a !== 1'b1 || word_done_a !== (i == 7) || word_done_b !== (i == 7)) begin errors++; $display("FAIL order_strobe w%0d bit%0d: got dv=%b wd=%b/%b", w, i, dout_valid_a, word_done_a, word_done_b); end
      end
      checks++; if (empty_a !== 1'b1 || level_a !== 2'd0 || state_a !== 1'b0) begin errors++; $display("FAIL order_drained w%0d: got empty=%b level=%0d state=%0d want 1/0/0", w, empty_a, level_a, state_a); end
      // shift request while empty is dropped
      do_cycle();
      checks++; if (dout_valid_a !== 1'b0 || word_done_a !== 1'b0 || dout_a !== seq_a[w][7] || dout_b !== seq_b[w][7]) begin errors++; $display("FAIL order_empty_shift w%0d: got dv=%b wd=%b dout=%b/%b", w, dout_valid_a, word_done_a, dout_a, dout_b); end
      shift_en = 1'b0;
    end
  endtask

  task automatic test_full();
    logic [7:0]  first_a, first_b;
    logic [15:0] rest;
    first_a = 8'h35; first_b = 8'hAC;
    rest = {8'h81, 8'hC3};
    load_word(8'h35);
    load_word(8'hC3);
    checks++; if (full_a !== 1'b1 || level_a !== 2'd2) begin errors++; $display("FAIL full_flags: got full=%b level=%0d want 1/2", full_a, level_a); end
    load_valid = 1'b1;
    load_data  = 8'h81;
    #1;
    checks++; if (load_ready_a !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", load_ready_a); end
    shift_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_cycle();
      checks++; if (dout_a !== first_a[i] || dout_b !== first_b[i]) begin errors++; $display("FAIL full_shift bit%0d: got %b/%b want %b/%b", i, dout_a, dout_b, first_a[i], first_b[i]); end
      checks++; if (level_a !== ((i == 7) ? 2'd1 : 2'd2)) begin errors++; $display("FAIL full_level bit%0d: got %0d", i, level_a); end
    end
    shift_en = 1'b0;
    #1;
    checks++; if (full_a !== 1'b0 || load_ready_a !== 1'b1) begin errors++; $display("FAIL full_freed: got full=%b ready=%b want 0/1", full_a, load_ready_a); end
    do_cycle();
    load_valid = 1'b0;
    checks++; if (level_a !== 2'd2 || full_a !== 1'b1) begin errors++; $display("FAIL full_third_load: got level=%0d full=%b want 2/1", level_a, full_a); end
    shift_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      do_cycle();
      checks++; if (dout_a !== rest[i] || dout_b !== rest[i]) begin errors++; $display("FAIL full_drain bit%0d: got %b/%b want %b", i, dout_a, dout_b, rest[i]); end
      checks++; if (word_done_a !== (i == 7 || i == 15)) begin errors++; $display("FAIL full_drain_done bit%0d: got %b", i, word_done_a); end
    end
    shift_en = 1'b0;
    checks++; if (empty_a !== 1'b1 || state_a !== 1'b0) begin errors++; $display("FAIL full_end: got empty=%b state=%0d want 1/0", empty_a, state_a); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] seq_a, seq_b;
    seq_a = {8'hF0, 8'h00, 8'hFF};
    seq_b = {8'h0F, 8'h00, 8'hFF};
    load_word(8'hFF);
    load_word(8'h00);
    shift_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      // new word arrives on the same edge as the final bit of the last stored word
      if (i == 15) begin load_valid = 1'b1; load_data = 8'hF0; end
      do_cycle();
      load_valid = 1'b0;
      checks++; if (dout_a !== seq_a[i] || dout_b !== seq_b[i] || dout_valid_a !== 1'b1) begin errors++; $display("FAIL b2b bit%0d: got %b/%b dv=%b want %b/%b", i, dout_a, dout_b, dout_valid_a, seq_a[i], seq_b[i]); end
      checks++; if (word_done_a !== (i == 7 || i == 15 || i == 23)) begin errors++; $display("FAIL b2b_done bit%0d: got %b", i, word_done_a); end
      if (i == 15) begin
        checks++; if (level_a !== 2'd1 || state_a !== 1'b1 || empty_a !== 1'b0) begin errors++; $display("FAIL b2b_swap: got level=%0d state=%0d empty=%b want 1/1/0", level_a, state_a, empty_a); end
      end
    end
    shift_en = 1'b0;
    checks++; if (empty_a !== 1'b1 || state_a !== 1'b0 || level_a !== 2'd0) begin errors++; $display("FAIL b2b_end: got empty=%b state=%0d level=%0d", empty_a, state_a, level_a); end
  endtask

  task automatic test_cs_pause_and_reset();
    logic [7:0] seq_a, seq_b;
    seq_a = 8'hB4; seq_b = 8'h2D;
    load_word(8'hB4);
    shift_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      checks++; if (dout_a !== seq_a[i] || dout_b !== seq_b[i]) begin errors++; $display("FAIL cs_pre bit%0d: got %b/%b want %b/%b", i, dout_a, dout_b, seq_a[i], seq_b[i]); end
    end
    cs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_cycle();
      checks++; if (dout_valid_a !== 1'b0 || dout_a !== seq_a[2] || dout_b !== seq_b[2] || load_ready_a !== 1'b0 || level_a !== 2'd1) begin errors++; $display("FAIL cs_hold cyc%0d: got dv=%b dout=%b/%b ready=%b level=%0d", i, dout_valid_a, dout_a, dout_b, load_ready_a, level_a); end
    end
    cs = 1'b1;
    for (int i = 3; i < 8; i++) begin
      do_cycle();
      checks++; if (dout_a !== seq_a[i] || dout_b !== seq_b[i] || word_done_a !== (i == 7)) begin errors++; $display("FAIL cs_resume bit%0d: got %b/%b wd=%b want %b/%b", i, dout_a, dout_b, word_done_a, seq_a[i], seq_b[i]); end
    end
    shift_en = 1'b0;
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL cs_end: got empty=%b want 1", empty_a); end

    // reset in the middle of a word
    load_word(8'hFF);
    shift_en = 1'b1;
    repeat (3) do_cycle();
    shift_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (dout_a !== 1'b0 || dout_b !== 1'b0 || dout_valid_a !== 1'b0 || word_done_a !== 1'b0) begin errors++; $display("FAIL rst_mid_out: got dout=%b/%b dv=%b wd=%b want 0", dout_a, dout_b, dout_valid_a, word_done_a); end
    checks++; if (empty_a !== 1'b1 || full_a !== 1'b0 || level_a !== 2'd0 || state_a !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got empty=%b full=%b level=%0d state=%0d", empty_a, full_a, level_a, state_a); end
    do_cycle();
    rst = 1'b0;
    load_word(8'h01);
    checks++; if (level_a !== 2'd1 || state_a !== 1'b1) begin errors++; $display("FAIL rst_first_load: got level=%0d state=%0d want 1/1", level_a, state_a); end
    seq_a = 8'h01; seq_b = 8'h80;
    shift_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_cycle();
      checks++; if (dout_a !== seq_a[i] || dout_b !== seq_b[i] || word_done_a !== (i == 7)) begin errors++; $display("FAIL rst_after bit%0d: got %b/%b wd=%b want %b/%b", i, dout_a, dout_b, word_done_a, seq_a[i], seq_b[i]); end
    end
    shift_en = 1'b0;
    checks++; if (empty_a !== 1'b1 || level_a !== 2'd0) begin errors++; $display("FAIL rst_after_end: got empty=%b level=%0d", empty_a, level_a); end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_full();
    test_back_to_back();
    test_cs_pause_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_pingpong_shifter.md
TX_PINGPONG_SHIFTER -- requirements
Module: tx_pingpong_shifter

Interface
REQ-001 Parameter WIDTH, default 32: bits per transmit word, legal values 8..64.
REQ-002 Parameter NBUF, default 2: number of word buffers, legal values 2..8.
REQ-003 Parameter MSB_FIRST, default 0: 0 shifts bit 0 first; 1 shifts bit WIDTH-1 first.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cs  in  1  chip select; when low, loads and shifts are ignored and all state is held.
REQ-007 load_valid  in  1  a word is offered on load_data.
REQ-008 load_data  in  WIDTH  word to enqueue.
REQ-009 load_ready  out  1  combinational, equal to cs & !full.
REQ-010 shift_en  in  1  request to emit one bit.
REQ-011 dout  out  1  registered serial data.
REQ-012 dout_valid  out  1  registered; high for one cycle after each accepted shift.
REQ-013 word_done  out  1  registered; one-cycle pulse with the last bit of a word.
REQ-014 empty  out  1  registered; high when no words are stored.
REQ-015 full  out  1  registered; high when NBUF words are stored.
REQ-016 level  out  $clog2(NBUF+1)  count of stored words.

Function
REQ-017 A load is accepted when load_valid & load_ready; the word is written at the write pointer, the write pointer wraps modulo NBUF, and level increments.
REQ-018 A shift is accepted when cs & shift_en & !empty.
REQ-019 On an accepted shift, dout takes the current bit of the head word and dout_valid is 1 on the next cycle (latency 1).
REQ-020 The current bit is selected by bit counter bidx (0..WIDTH-1): bit bidx when MSB_FIRST=0, bit WIDTH-1-bidx when MSB_FIRST=1.
REQ-021 The head word is not modified during shifting; stored buffer contents are never shifted in place.
REQ-022 When bidx=WIDTH-1 on an accepted shift, the following happen on the same cycle: word_done pulses, bidx returns to 0, the read pointer advances modulo NBUF, and level decrements.
REQ-023 The state machine has two states. IDLE (empty=1) moves to SHIFT on an accepted load. SHIFT moves to IDLE when the final bit of the last stored word is shifted and no load is accepted in that cycle.
REQ-024 A simultaneous accepted load and final-bit shift leaves level unchanged; both pointers advance.
REQ-025 load_ready is evaluated before the final-bit release, so a full buffer rejects a load in the same cycle a slot frees.
REQ-026 A shift request while empty is ignored: dout holds, dout_valid=0, word_done=0.
REQ-027 A shift request while cs=0 is ignored: dout holds, dout_valid=0, bidx is preserved, and shifting resumes mid-word when cs returns high.
REQ-028 Back-to-back shifts across a word boundary produce no gap cycle: bit 0 of the next word follows the last bit of the previous word on the next shift.

Reset
REQ-029 While rst=1, the following hold: dout=0, dout_valid=0, word_done=0, empty=1, full=0, level=0, both pointers=0, bidx=0, state=IDLE.
REQ-030 Reset asserted mid-word discards all stored words and the partial word; buffer contents are don't-care.
REQ-031 The first load is accepted on the first rising edge after rst deasserts.

Structure
REQ-032 Package tx_shift_pkg holds the state enum (IDLE, SHIFT) and constants MIN_WIDTH=8, MAX_WIDTH=64, MAX_NBUF=8.
REQ-033 The NBUF-deep word store, pointers, level, empty and full are implemented in sub-module tx_word_fifo. tx_pingpong_shifter implements bidx, bit selection, the state machine and the output registers.
REQ-034 Illegal parameter values cause an elaboration-time error.

Verification
REQ-035 WIDTH=8, MSB_FIRST=0: load 8'hA5, then 8 consecutive shifts -> dout sequence 1,0,1,0,0,1,0,1; word_done on the 8th bit; then empty=1.
REQ-036 WIDTH=8, MSB_FIRST=1: load 8'hA5 -> dout sequence 1,0,1,0,0,1,0,1 taken from bit 7 down to bit 0 (confirm against 8'h5A being reversed).
REQ-037 NBUF=2: load 3 words while cs=1 -> third load sees load_ready=0, full=1, level=2; after 8 shifts the third load is accepted.
REQ-038 WIDTH=8: load 8'hFF and 8'h00, shift 16 times continuously -> 8 ones then 8 zeros with no gap; word_done at bits 8 and 16.
REQ-039 Shift 3 bits, drop cs for 5 cycles while pulsing shift_en, then restore cs -> bits 4..8 resume with no loss; then pulse rst mid-word -> all outputs at reset values.
